// File: rtl/login_pkg.sv
// Shared types and constants for the keypad login sequencer.
package login_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ENTRY, ST_CHECK, ST_LOGGED_IN,
    ST_CMD, ST_CMD_HOLD, ST_LOGOUT, ST_LOCKOUT
  } state_t;

  // Bit positions in btn_req; bit N drives output btn(N+1).
  localparam int CMD_LOGOUT      = 0;
  localparam int CMD_RESET_PW    = 1;
  localparam int CMD_ADD_USER    = 2;
  localparam int CMD_CHANGE_PW   = 3;
  localparam int CMD_DELETE_USER = 4;

  localparam int DEF_CHECK_CYCLES   = 4;
  localparam int DEF_MAX_FAIL       = 3;
  localparam int DEF_LOCKOUT_CYCLES = 1000;
  localparam int DEF_CMD_HOLD       = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Fixed priority: lowest set bit wins.
  function automatic logic [4:0] prio_grant(input logic [4:0] req);
    return req & (~req + 5'd1);
  endfunction

endpackage

// File: rtl/login_sequencer_if.sv
// Keypad, command-button and unlocker signals of the login sequencer.
interface login_sequencer_if;
  logic       digit_valid;
  logic [3:0] digit;
  logic       clear;
  logic [4:0] btn_req;
  logic       lock;

  logic [3:0] inputCount;
  logic [3:0] userNameInput0, userNameInput1, userNameInput2, userNameInput3;
  logic [3:0] passwordInput0, passwordInput1, passwordInput2, passwordInput3;
  logic       btn1, btn2, btn3, btn4, btn5;
  logic       lockout;
  logic [1:0] fail_count;

  modport master (
    output digit_valid, digit, clear, btn_req, lock,
    input  inputCount,
    input  userNameInput0, userNameInput1, userNameInput2, userNameInput3,
    input  passwordInput0, passwordInput1, passwordInput2, passwordInput3,
    input  btn1, btn2, btn3, btn4, btn5, lockout, fail_count
  );

  modport slave (
    input  digit_valid, digit, clear, btn_req, lock,
    output inputCount,
    output userNameInput0, userNameInput1, userNameInput2, userNameInput3,
    output passwordInput0, passwordInput1, passwordInput2, passwordInput3,
    output btn1, btn2, btn3, btn4, btn5, lockout, fail_count
  );
endinterface

// File: rtl/lockout_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module lockout_timer #(
  parameter int MAX_CYCLES = 1000,
  localparam int W = $clog2(MAX_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt_q <= '0;
    else if (load)        cnt_q <= load_val;
    else if (cnt_q != '0) cnt_q <= cnt_q - W'(1);
  end

  assign done = (cnt_q == '0);
endmodule

// File: rtl/login_sequencer.sv
// Keypad login FSM: 8-digit entry, unlocker check, command buttons, lockout.
module login_sequencer
  import login_pkg::*;
#(
  parameter int CHECK_CYCLES   = DEF_CHECK_CYCLES,
  parameter int MAX_FAIL       = DEF_MAX_FAIL,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int CMD_HOLD       = DEF_CMD_HOLD
) (
  input logic              clk,
  input logic              rst,
  login_sequencer_if.slave bus
);
  localparam int TMAX = max3(LOCKOUT_CYCLES, CHECK_CYCLES, CMD_HOLD);
  localparam int TW   = $clog2(TMAX + 1);
  // Timer counts down to zero inclusive, so load N-1 for an N-cycle wait.
  localparam logic [TW-1:0] CHECK_LD = TW'(CHECK_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LD  = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LD  = TW'(CMD_HOLD - 1);
  localparam logic [1:0]    MAXF     = 2'(MAX_FAIL);

  state_t        state_q, state_n;
  logic [3:0]    count_q, count_n;
  logic [3:0]    dig_q [8];
  logic [3:0]    dig_n [8];
  logic [4:0]    btn_q, btn_n, prev_q, grant;
  logic [1:0]    fail_q, fail_n, fail_inc;
  logic          lockout_q, lockout_n, need8_q, need8_n;
  logic          accept, t_load, t_done;
  logic [TW-1:0] t_val;

  lockout_timer #(.MAX_CYCLES(TMAX)) u_timer (
    .clk(clk), .rst(rst), .load(t_load), .load_val(t_val), .done(t_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      btn_q     <= '0;
      prev_q    <= '0;
      fail_q    <= '0;
      lockout_q <= 1'b0;
      need8_q   <= 1'b0;
      for (int i = 0; i < 8; i++) dig_q[i] <= '0;
    end else begin
      state_q   <= state_n;
      count_q   <= count_n;
      btn_q     <= btn_n;
      prev_q    <= bus.btn_req;
      fail_q    <= fail_n;
      lockout_q <= lockout_n;
      need8_q   <= need8_n;
      dig_q     <= dig_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    count_n   = count_q;
    dig_n     = dig_q;
    btn_n     = btn_q;
    fail_n    = fail_q;
    lockout_n = lockout_q;
    need8_n   = need8_q;
    t_load    = 1'b0;
    t_val     = '0;
    accept    = bus.digit_valid && (bus.digit <= 4'd9) && !bus.clear;
    grant     = prio_grant(bus.btn_req & ~prev_q);
    fail_inc  = (fail_q == MAXF) ? fail_q : fail_q + 2'd1;

    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (bus.clear) begin
          count_n = '0;
          dig_n   = '{default: 4'd0};
          state_n = ST_IDLE;
        end else if (accept) begin
          dig_n[count_q[2:0]] = bus.digit;
          count_n = count_q + 4'd1;
          state_n = ST_ENTRY;
          if (count_q == 4'd7) begin
            state_n = ST_CHECK;
            t_load  = 1'b1;
            t_val   = CHECK_LD;
          end
        end
      end
      ST_CHECK: begin
        if (t_done) begin
          if (!bus.lock) begin
            state_n = ST_LOGGED_IN;
            fail_n  = '0;
          end else begin
            fail_n  = fail_inc;
            count_n = '0;
            state_n = ST_IDLE;
            if (fail_inc == MAXF) begin
              state_n   = ST_LOCKOUT;
              lockout_n = 1'b1;
              t_load    = 1'b1;
              t_val     = LOCK_LD;
            end
          end
        end
      end
      ST_LOGGED_IN: begin
        if (grant[CMD_LOGOUT]) begin
          btn_n   = grant;
          count_n = '0;
          state_n = ST_LOGOUT;
          t_load  = 1'b1;
          t_val   = HOLD_LD;
        end else if (grant != '0) begin
          btn_n   = grant;
          count_n = '0;
          need8_n = grant[CMD_ADD_USER] | grant[CMD_CHANGE_PW];
          state_n = ST_CMD;
        end
      end
      ST_CMD: begin
        if (bus.clear) begin
          count_n = '0;
          dig_n   = '{default: 4'd0};
          btn_n   = '0;
          state_n = ST_LOGGED_IN;
        end else if (accept) begin
          dig_n[count_q[2:0]] = bus.digit;
          count_n = count_q + 4'd1;
          if (count_n == (need8_q ? 4'd8 : 4'd4)) begin
            state_n = ST_CMD_HOLD;
            t_load  = 1'b1;
            t_val   = HOLD_LD;
          end
        end
      end
      ST_CMD_HOLD, ST_LOGOUT: begin
        if (t_done) begin
          btn_n   = '0;
          count_n = '0;
          state_n = (state_q == ST_LOGOUT) ? ST_IDLE : ST_LOGGED_IN;
        end
      end
      ST_LOCKOUT: begin
        if (t_done) begin
          lockout_n = 1'b0;
          fail_n    = '0;
          count_n   = '0;
          state_n   = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.inputCount     = count_q;
  assign bus.userNameInput0 = dig_q[0];
  assign bus.userNameInput1 = dig_q[1];
  assign bus.userNameInput2 = dig_q[2];
  assign bus.userNameInput3 = dig_q[3];
  assign bus.passwordInput0 = dig_q[4];
  assign bus.passwordInput1 = dig_q[5];
  assign bus.passwordInput2 = dig_q[6];
  assign bus.passwordInput3 = dig_q[7];
  assign bus.btn1           = btn_q[CMD_LOGOUT];
  assign bus.btn2           = btn_q[CMD_RESET_PW];
  assign bus.btn3           = btn_q[CMD_ADD_USER];
  assign bus.btn4           = btn_q[CMD_CHANGE_PW];
  assign bus.btn5           = btn_q[CMD_DELETE_USER];
  assign bus.lockout        = lockout_q;
  assign bus.fail_count     = fail_q;
endmodule

// File: tb/tb_login_sequencer.sv
// Directed-vector bench for login_sequencer with hand-computed expectations.
module tb_login_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hi_cnt;

  login_sequencer_if bus ();

  login_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] btns();
    return {bus.btn5, bus.btn4, bus.btn3, bus.btn2, bus.btn1};
  endfunction

  // Keys the eight digits of code (most significant nibble first).
  task automatic enter_code(input logic [31:0] code, input bit chk_cnt);
    for (int i = 0; i < 8; i++) begin
      bus.digit_valid = 1'b1;
      bus.digit       = code[31-4*i -: 4];
      tick();
      if (chk_cnt) check("entry_count", 32'(bus.inputCount), 32'(i + 1));
    end
    bus.digit_valid = 1'b0;
  endtask

  task automatic send_digit(input logic [3:0] d);
    bus.digit_valid = 1'b1;
    bus.digit       = d;
    tick();
    bus.digit_valid = 1'b0;
  endtask

  task automatic repeat_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
    bus.clear       = 1'b0;
    bus.btn_req     = 5'd0;
    bus.lock        = 1'b1;
    repeat_ticks(2);
    check("rst_count", 32'(bus.inputCount), 0);
    check("rst_btns", 32'(btns()), 0);
    check("rst_lockout", 32'(bus.lockout), 0);
    check("rst_fail", 32'(bus.fail_count), 0);
    rst = 1'b0;
    tick();

    // Correct login: lock drops while the code is being checked.
    enter_code(32'h0011_0011, 1'b1);
    bus.lock = 1'b0;
    repeat_ticks(6);
    check("login_fail", 32'(bus.fail_count), 0);
    check("login_count", 32'(bus.inputCount), 8);
    check("login_user2", 32'(bus.userNameInput2), 1);
    check("login_pw3", 32'(bus.passwordInput3), 1);

    // Two simultaneous edges: bit1 beats bit2.
    bus.btn_req = 5'b00110;
    tick();
    bus.btn_req = 5'b00000;
    check("prio_btns", 32'(btns()), 32'b00010);
    check("prio_count", 32'(bus.inputCount), 0);
    send_digit(4'd2);
    send_digit(4'd0);
    send_digit(4'd1);
    send_digit(4'd1);
    check("rpw_count", 32'(bus.inputCount), 4);
    check("rpw_user0", 32'(bus.userNameInput0), 2);
    check("rpw_hold0", 32'(btns()), 32'b00010);
    tick();
    check("rpw_hold1", 32'(btns()), 32'b00010);
    tick();
    check("rpw_release", 32'(btns()), 0);
    check("rpw_count_end", 32'(bus.inputCount), 0);

    // Add-user aborted by clear after five digits.
    bus.btn_req = 5'b00100;
    tick();
    bus.btn_req = 5'b00000;
    check("add_btns", 32'(btns()), 32'b00100);
    for (int i = 0; i < 5; i++) send_digit(4'(i + 3));
    check("add_count5", 32'(bus.inputCount), 5);
    check("add_still_on", 32'(btns()), 32'b00100);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("add_abort_btns", 32'(btns()), 0);
    check("add_abort_count", 32'(bus.inputCount), 0);
    check("add_abort_user0", 32'(bus.userNameInput0), 0);

    // Logout pulse then back to IDLE.
    bus.btn_req = 5'b00001;
    tick();
    bus.btn_req = 5'b00000;
    check("logout_btn1", 32'(btns()), 32'b00001);
    tick();
    check("logout_hold", 32'(btns()), 32'b00001);
    tick();
    check("logout_release", 32'(btns()), 0);
    check("logout_fail", 32'(bus.fail_count), 0);

    // Illegal digit ignored; clear beats a simultaneous digit.
    send_digit(4'd3);
    check("entry_first", 32'(bus.inputCount), 1);
    send_digit(4'd12);
    check("illegal_digit", 32'(bus.inputCount), 1);
    bus.clear = 1'b1;
    send_digit(4'd4);
    bus.clear = 1'b0;
    check("clear_wins", 32'(bus.inputCount), 0);

    // Three wrong logins lead to lockout.
    bus.lock = 1'b1;
    enter_code(32'h1234_5678, 1'b0);
    repeat_ticks(6);
    check("fail1", 32'(bus.fail_count), 1);
    check("fail1_count", 32'(bus.inputCount), 0);
    enter_code(32'h1234_5678, 1'b0);
    repeat_ticks(6);
    check("fail2", 32'(bus.fail_count), 2);
    check("fail2_lockout", 32'(bus.lockout), 0);
    enter_code(32'h1234_5678, 1'b0);
    repeat_ticks(3);
    check("lockout_pre", 32'(bus.lockout), 0);
    tick();
    check("lockout_on", 32'(bus.lockout), 1);
    check("lockout_fail", 32'(bus.fail_count), 3);
    hi_cnt = 1;
    send_digit(4'd5);
    if (bus.lockout) hi_cnt++;
    check("lockout_ignores", 32'(bus.inputCount), 0);
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (!bus.lockout) break;
      hi_cnt++;
    end
    check("lockout_len", 32'(hi_cnt), 1000);
    check("lockout_done_fail", 32'(bus.fail_count), 0);
    check("lockout_done_count", 32'(bus.inputCount), 0);
    send_digit(4'd7);
    check("post_lockout_entry", 32'(bus.inputCount), 1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;

    // Asynchronous reset in the middle of a second lockout.
    for (int k = 0; k < 3; k++) begin
      enter_code(32'h9999_9999, 1'b0);
      repeat_ticks(6);
    end
    repeat_ticks(20);
    check("lockout2_on", 32'(bus.lockout), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_lockout", 32'(bus.lockout), 0);
    check("async_fail", 32'(bus.fail_count), 0);
    check("async_btns", 32'(btns()), 0);
    repeat_ticks(2);
    rst = 1'b0;
    bus.lock = 1'b0;
    enter_code(32'h0011_0011, 1'b0);
    repeat_ticks(6);
    check("relogin_count", 32'(bus.inputCount), 8);
    bus.btn_req = 5'b10000;
    tick();
    bus.btn_req = 5'b00000;
    check("delete_btns", 32'(btns()), 32'b10000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
